// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encoding, parity
// constants and frame-length helpers.
package uart_tx_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP1  = 3'd4;
  localparam logic [2:0] ENC_STOP2  = 3'd5;
  localparam logic [2:0] ENC_BRK    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_START  = ENC_START,
    ST_DATA   = ENC_DATA,
    ST_PARITY = ENC_PARITY,
    ST_STOP1  = ENC_STOP1,
    ST_STOP2  = ENC_STOP2,
    ST_BRK    = ENC_BRK
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int START_BITS    = 1;
  localparam int STOP_BITS_MIN = 1;

  // Line cycles occupied by one frame for a given configuration.
  function automatic int frame_len(input int data_width, input logic par_en,
                                   input logic stop2);
    return START_BITS + data_width + int'(par_en) + STOP_BITS_MIN + int'(stop2);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter; presents the
// next data bit on ser_bit and flags the last data bit with ser_done.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  load,
  input  logic                  shift,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;
  logic                  primed;

  assign ser_bit  = MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0];
  assign ser_done = (cnt == CNT_W'(DATA_WIDTH - 1));

  // The first shift (leaving START) only pre-advances the register, so the
  // counter stays at 0 for the first DATA cycle and counts from then on.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      cnt    <= '0;
      primed <= 1'b0;
    end else if (load) begin
      sreg   <= data;
      cnt    <= '0;
      primed <= 1'b0;
    end else if (shift) begin
      sreg   <= MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, sreg[DATA_WIDTH-1:1]};
      primed <= 1'b1;
      if (primed && !ser_done) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter sending one bit per CLK with registered TX_OUT/Busy.
// Optional break generation (BREAK input, BRK state) with UART_TX_BREAK_EN.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK,
`endif
  output logic                  Data_Ack,
  output logic                  TX_OUT,
  output logic                  Busy
);

  state_t state, state_next;
  logic   par_en_q, stop2_q, par_bit_q;
  logic   tx_next, busy_next, ack_next;
  logic   load, shift, accept;
  logic   ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .data     (P_DATA),
    .load     (load),
    .shift    (shift),
    .ser_bit  (ser_bit),
    .ser_done (ser_done)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    busy_next  = 1'b0;
    ack_next   = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (BREAK) begin
          state_next = ST_BRK;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end else
`endif
        accept = Data_Valid;
      end
      ST_START: begin
        state_next = ST_DATA;
        tx_next    = ser_bit;
        busy_next  = 1'b1;
        shift      = 1'b1;
      end
      ST_DATA: begin
        busy_next = 1'b1;
        if (!ser_done) begin
          tx_next = ser_bit;
          shift   = 1'b1;
        end else if (par_en_q) begin
          state_next = ST_PARITY;
          tx_next    = par_bit_q;
        end else begin
          state_next = ST_STOP1;
        end
      end
      ST_PARITY: begin
        state_next = ST_STOP1;
        busy_next  = 1'b1;
      end
      ST_STOP1: begin
        if (stop2_q) begin
          state_next = ST_STOP2;
          busy_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
          accept     = Data_Valid;
        end
      end
      ST_STOP2: begin
        state_next = ST_IDLE;
        accept     = Data_Valid;
      end
`ifdef UART_TX_BREAK_EN
      ST_BRK: begin
        busy_next = 1'b1;
        if (BREAK) tx_next = 1'b0;
        else       state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase

    // Acceptance overrides the final-stop exit so frames run back-to-back.
    if (accept) begin
      state_next = ST_START;
      tx_next    = 1'b0;
      busy_next  = 1'b1;
      ack_next   = 1'b1;
      load       = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      Data_Ack  <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state    <= state_next;
      TX_OUT   <= tx_next;
      Busy     <= busy_next;
      Data_Ack <= ack_next;
      if (load) begin
        par_en_q  <= PAR_EN;
        stop2_q   <= STOP2;
        par_bit_q <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: an 8-bit LSB-first instance and a
// 5-bit MSB-first instance checked cycle by cycle against a frame model.
module tb_uart_tx_engine;
  import uart_tx_pkg::frame_len;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] p_data8;
  logic [4:0] p_data5;
  logic       dv8, dv5, par_en, par_typ, stop2;
  logic       ack8, tx8, busy8, ack5, tx5, busy5;
`ifdef UART_TX_BREAK_EN
  logic       brk;
  int         brk_drop_at;
`endif

  int checks = 0;
  int errors = 0;

  // Expected per-cycle line, Busy and Data_Ack, starting the cycle after
  // the accepting edge.
  bit exp_tx[$];
  bit exp_busy[$];
  bit exp_ack[$];

  logic [7:0] sw_data8;
  logic [4:0] sw_data5;
  logic       sw_pe, sw_pt, sw_s2;

  always #5 CLK = ~CLK;

  uart_tx_engine #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (p_data8),
    .Data_Valid (dv8),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK      (brk),
`endif
    .Data_Ack   (ack8),
    .TX_OUT     (tx8),
    .Busy       (busy8)
  );

  uart_tx_engine #(.DATA_WIDTH(5), .MSB_FIRST(1'b1)) u_dut5 (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (p_data5),
    .Data_Valid (dv5),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .STOP2      (stop2),
`ifdef UART_TX_BREAK_EN
    .BREAK      (1'b0),
`endif
    .Data_Ack   (ack5),
    .TX_OUT     (tx5),
    .Busy       (busy5)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input bit tx, input bit busy, input bit ack);
    exp_tx.push_back(tx);
    exp_busy.push_back(busy);
    exp_ack.push_back(ack);
  endtask

  task automatic clear_model();
    exp_tx.delete();
    exp_busy.delete();
    exp_ack.delete();
  endtask

  // Frame as seen on the line: start, data in chosen order, parity, stops.
  task automatic add_frame(input logic [8:0] d, input int dw, input bit msb,
                           input bit pe, input bit pt, input bit s2);
    int ones = 0;
    push(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < dw; k++) begin
      int idx = msb ? dw - 1 - k : k;
      if (d[idx]) ones++;
      push(d[idx], 1'b1, 1'b0);
    end
    if (pe) push(pt ? (ones % 2 == 0) : (ones % 2 == 1), 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    if (s2) push(1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) push(1'b1, 1'b0, 1'b0);
  endtask

  task automatic scramble_inputs();
    p_data8 = 8'($urandom);
    p_data5 = 5'($urandom);
    par_en  = 1'($urandom);
    par_typ = 1'($urandom);
    stop2   = 1'($urandom);
  endtask

  // Walks the expected queues one cycle at a time, sampling at the falling
  // edge, and applies scheduled input changes after each sample.
  task automatic run_frames(input string tag, input bit sel, input bit scramble,
                            input int swap_at, input int drop_at);
    for (int i = 0; i < exp_tx.size(); i++) begin
      @(negedge CLK);
      check($sformatf("%s[%0d] tx", tag, i),   sel ? tx5   : tx8,   exp_tx[i]);
      check($sformatf("%s[%0d] busy", tag, i), sel ? busy5 : busy8, exp_busy[i]);
      check($sformatf("%s[%0d] ack", tag, i),  sel ? ack5  : ack8,  exp_ack[i]);
      if (i == swap_at) begin
        p_data8 = sw_data8;
        p_data5 = sw_data5;
        par_en  = sw_pe;
        par_typ = sw_pt;
        stop2   = sw_s2;
      end
      if (i == drop_at) begin
        dv8 = 1'b0;
        dv5 = 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      if (i == brk_drop_at) brk = 1'b0;
`endif
      if (scramble) scramble_inputs();
    end
  endtask

  initial begin
    logic [8:0] d1, d2;
    bit         sel, pe1, pt1, s21, pe2, pt2, s22, b2b;
    int         dw, len1, gap;

    RST = 1'b1;
    p_data8 = '0; p_data5 = '0;
    dv8 = 1'b0; dv5 = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
    brk_drop_at = -1;
`endif
    repeat (2) @(negedge CLK);
    check("reset tx8", tx8, 1'b1);
    check("reset busy8", busy8, 1'b0);
    check("reset ack8", ack8, 1'b0);
    check("reset tx5", tx5, 1'b1);
    check("reset busy5", busy5, 1'b0);
    check("reset ack5", ack5, 1'b0);
    RST = 1'b0;

    // Reset in the middle of a frame returns the line to idle next cycle.
    p_data8 = 8'h5A; par_en = 1'b1; dv8 = 1'b1;
    @(negedge CLK);
    dv8 = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midreset tx", tx8, 1'b1);
    check("midreset busy", busy8, 1'b0);
    check("midreset ack", ack8, 1'b0);
    RST = 1'b0;

    // 0xA5, even parity, one stop bit.
    clear_model();
    add_frame(9'h0A5, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    add_idle(2);
    p_data8 = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv8 = 1'b1;
    run_frames("a5_even", 1'b0, 1'b0, -1, 0);

    // 0xA5, odd parity, two stops; inputs scrambled and Data_Valid held
    // through the first stop bit, which must not accept.
    clear_model();
    add_frame(9'h0A5, 8, 1'b0, 1'b1, 1'b1, 1'b1);
    add_idle(2);
    p_data8 = 8'hA5; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; dv8 = 1'b1;
    run_frames("a5_odd", 1'b0, 1'b1, -1, 10);

    // Back-to-back 0x3C then 0xFF with Data_Valid held.
    clear_model();
    add_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(9'h0FF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(2);
    p_data8 = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv8 = 1'b1;
    sw_data8 = 8'hFF; sw_data5 = '0; sw_pe = 1'b0; sw_pt = 1'b0; sw_s2 = 1'b0;
    run_frames("b2b", 1'b0, 1'b0, 0, 10);

    // Five-bit MSB-first instance.
    clear_model();
    add_frame(9'b0_0001_0011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    add_idle(2);
    p_data5 = 5'b10011; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv5 = 1'b1;
    run_frames("msb5", 1'b1, 1'b0, -1, 0);

`ifdef UART_TX_BREAK_EN
    // Break for 20 cycles with Data_Valid pending, one mark, then the frame.
    clear_model();
    for (int k = 0; k < 20; k++) push(1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b1, 1'b0);
    add_frame(9'h0C3, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    add_idle(2);
    p_data8 = 8'hC3; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    brk = 1'b1; dv8 = 1'b1; brk_drop_at = 19;
    run_frames("break", 1'b0, 1'b0, -1, 21);
    brk_drop_at = -1;
`endif

    // Randomized frames on both instances, some back-to-back with a new
    // configuration presented right after the first acceptance.
    for (int it = 0; it < 14; it++) begin
      sel = 1'($urandom);
      dw  = sel ? 5 : 8;
      d1  = 9'($urandom);
      d2  = 9'($urandom);
      pe1 = 1'($urandom); pt1 = 1'($urandom); s21 = 1'($urandom);
      pe2 = 1'($urandom); pt2 = 1'($urandom); s22 = 1'($urandom);
      b2b = (it % 3 == 2);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge CLK);
      clear_model();
      add_frame(d1, dw, sel, pe1, pt1, s21);
      len1 = frame_len(dw, pe1, s21);
      if (b2b) add_frame(d2, dw, sel, pe2, pt2, s22);
      add_idle(2);
      p_data8 = d1[7:0]; p_data5 = d1[4:0];
      par_en = pe1; par_typ = pt1; stop2 = s21;
      sw_data8 = d2[7:0]; sw_data5 = d2[4:0];
      sw_pe = pe2; sw_pt = pt2; sw_s2 = s22;
      if (sel) dv5 = 1'b1;
      else     dv8 = 1'b1;
      run_frames($sformatf("rand%0d", it), sel, !b2b, b2b ? 0 : -1, b2b ? len1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
